// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if
//   Bundles the register-file view of the PWM block with its pin-side outputs.
//   master : owner of the control registers (SPI register block / testbench);
//            drives the enables and duty, observes the pins.
//   slave  : the PWM peripheral itself.
//   Signals:
//     en_reg_out_7_0 / en_reg_out_15_8  output enables, pins 7..0 / 15..8
//     en_reg_pwm_7_0 / en_reg_pwm_15_8  PWM select, pins 7..0 / 15..8
//     pwm_duty_cycle                    requested duty (0x00 low, 0xFF high)
//     out                               registered pin drive, bit i = pin i
//     period_start                      one-clk pulse on period counter wrap
interface pwm_peripheral_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   modport master (
      output en_reg_out_7_0,
      output en_reg_out_15_8,
      output en_reg_pwm_7_0,
      output en_reg_pwm_15_8,
      output pwm_duty_cycle,
      input  out,
      input  period_start
   );

   modport slave (
      input  en_reg_out_7_0,
      input  en_reg_out_15_8,
      input  en_reg_pwm_7_0,
      input  en_reg_pwm_15_8,
      input  pwm_duty_cycle,
      output out,
      output period_start
   );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Drives 16 pins from the SPI-written control registers. Each pin is forced
//   low, held static high, or follows one shared PWM waveform. A prescaler
//   steps an 8-bit period counter every CLK_DIV clocks; the duty request is
//   shadowed at the period wrap so a mid-period write never glitches a pin.
//   Ports:
//     clk  system clock (only clock)
//     rst  asynchronous, active-high reset
//     bus  pwm_peripheral_if.slave: enables, duty in; out, period_start out
//   Parameters:
//     CLK_DIV  clk cycles per counter step, 1..4095 (period = 256*CLK_DIV)
//     DIV_W    prescaler width, 2**DIV_W >= CLK_DIV
module pwm_peripheral #(
   parameter int CLK_DIV = 13,
   parameter int DIV_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   pwm_peripheral_if.slave   bus
);

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] presc;
   logic [7:0]       cnt;
   logic [7:0]       duty_q;
   logic             tick;
   logic             wrap;
   logic             pwm_raw;
   logic [15:0]      en_out;
   logic [15:0]      en_pwm;

   assign tick   = (presc == PRESC_LAST);
   assign wrap   = tick & (cnt == 8'hFF);
   assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
   assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

   // 0xFF is special-cased so full scale is truly always-high, not 255/256.
   assign pwm_raw = (duty_q == 8'hFF) | (cnt < duty_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'h00;
      end else if (tick) begin
         cnt <= cnt + 8'h01;
      end
   end

   // Duty is only sampled on the wrap cycle so it is live from cnt == 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q <= 8'h00;
      end else if (wrap) begin
         duty_q <= bus.pwm_duty_cycle;
      end
   end

   // Registered pin mux and wrap marker; period_start is high in the cycle
   // where cnt first reads 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out          <= 16'h0000;
         bus.period_start <= 1'b0;
      end else begin
         bus.out          <= en_out & (~en_pwm | {16{pwm_raw}});
         bus.period_start <= wrap;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral
//   Bench for pwm_peripheral at CLK_DIV = 4 (1024-clk period). A reference
//   model tracks elapsed clocks since reset and derives pin values from the
//   position within the period and the duty captured at each period end.
//   Directed phases cover reset, static mux, duty levels and boundaries,
//   shadow timing and mid-period enable changes; a random phase follows.
module tb_pwm_peripheral;

   localparam int DIV = 4;
   localparam int PER = 256 * DIV;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   bit   chk_en;

   pwm_peripheral_if bus();

   pwm_peripheral #(.CLK_DIV(DIV), .DIV_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: clocks since reset release, duty in effect for the
   // current period, and the pin/pulse values expected after each edge.
   int          clk_idx;
   logic [7:0]  duty_m;
   logic [15:0] exp_out;
   logic        exp_ps;

   always @(posedge clk or posedge rst) begin
      int          phase;
      bit          high;
      logic [15:0] e;
      logic [15:0] p;
      if (rst) begin
         clk_idx = 0;
         duty_m  = 8'h00;
         exp_out = 16'h0000;
         exp_ps  = 1'b0;
      end else begin
         phase   = clk_idx % PER;
         high    = (duty_m == 8'hFF) || (phase < int'(duty_m) * DIV);
         e       = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
         p       = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
         exp_out = e & (~p | {16{high}});
         exp_ps  = (phase == PER - 1);
         if (phase == PER - 1) duty_m = bus.pwm_duty_cycle;
         clk_idx++;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("model_out", bus.out, exp_out);
         chk("model_period_start", bus.period_start, exp_ps);
      end
   end

   task automatic set_ep(input logic [15:0] e, input logic [15:0] p);
      bus.en_reg_out_7_0  = e[7:0];
      bus.en_reg_out_15_8 = e[15:8];
      bus.en_reg_pwm_7_0  = p[7:0];
      bus.en_reg_pwm_15_8 = p[15:8];
   endtask

   task automatic wait_ps;
      int k;
      k = 0;
      @(negedge clk);
      while (!bus.period_start && k < 2 * PER) begin
         @(negedge clk);
         k++;
      end
      chk("wait_period_start", bus.period_start, 1);
   endtask

   // Samples n negedges; optionally rewrites duty after sample change_at.
   task automatic count_window(input int n, input int change_at, input logic [7:0] new_duty,
                               output int hi, output int ps_cnt, output bit ps_last,
                               output bit first_val);
      hi = 0; ps_cnt = 0; ps_last = 0; first_val = 0;
      for (int i = 0; i < n; i++) begin
         if (i == change_at) bus.pwm_duty_cycle = new_duty;
         @(negedge clk);
         if (i == 0) first_val = bus.out[0];
         if (bus.out[0]) hi++;
         if (bus.period_start) begin
            ps_cnt++;
            if (i == n - 1) ps_last = 1;
         end
      end
   endtask

   task automatic run_duty(input string tag, input logic [7:0] duty, input int exp_hi,
                           input bit check_rise);
      int  hi, ps_cnt;
      bit  ps_last, first_val, out0_at_ps;
      set_ep(16'h0001, 16'h0001);
      bus.pwm_duty_cycle = duty;
      wait_ps;
      out0_at_ps = bus.out[0];
      for (int per = 0; per < 2; per++) begin
         count_window(PER, -1, 8'h00, hi, ps_cnt, ps_last, first_val);
         chk({tag, "_high_clks"}, hi, exp_hi);
         chk({tag, "_ps_count"}, ps_cnt, 1);
         chk({tag, "_ps_spacing"}, ps_last, 1);
         if (check_rise && per == 0) begin
            chk({tag, "_low_at_ps"}, out0_at_ps, 0);
            chk({tag, "_rise_after_ps"}, first_val, 1);
         end
      end
   endtask

   initial begin
      int  hi, ps_cnt, bad;
      bit  ps_last, first_val;
      logic [15:0] e, p;

      n_chk = 0; n_fail = 0; chk_en = 0;
      rst = 1'b1;
      set_ep(16'hFFFF, 16'h0000);
      bus.pwm_duty_cycle = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1;

      // Async reset mid-period with static-high pins.
      repeat (300) @(negedge clk);
      chk("pre_reset_out", bus.out, 16'hFFFF);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_out", bus.out, 16'h0000);
      chk("async_reset_ps", bus.period_start, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release_out", bus.out, 16'hFFFF);

      // Static mux with duty 0 loaded.
      set_ep(16'h00F0, 16'h0030);
      bus.pwm_duty_cycle = 8'h00;
      wait_ps;
      bad = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         if (bus.out !== 16'h00C0) bad++;
      end
      chk("static_mux_bad_clks", bad, 0);

      run_duty("duty80", 8'h80, 512, 1);
      run_duty("duty00", 8'h00, 0, 0);
      run_duty("dutyFF", 8'hFF, PER, 0);
      run_duty("duty01", 8'h01, DIV, 0);

      // Shadow: 0x40 loaded, 0xC0 written at cnt = 10.
      set_ep(16'h0001, 16'h0001);
      bus.pwm_duty_cycle = 8'h40;
      wait_ps;
      count_window(PER, 40, 8'hC0, hi, ps_cnt, ps_last, first_val);
      chk("shadow_cur_high", hi, 256);
      chk("shadow_cur_ps", ps_last, 1);
      count_window(PER, -1, 8'h00, hi, ps_cnt, ps_last, first_val);
      chk("shadow_next_high", hi, 768);
      chk("shadow_next_ps", ps_last, 1);
      chk("shadow_next_ps_count", ps_cnt, 1);

      // Enable drop mid-period while pwm_raw is high (duty 0xC0).
      wait_ps;
      repeat (10) @(negedge clk);
      chk("en_drop_before", bus.out[0], 1);
      bus.en_reg_out_7_0 = 8'h00;
      @(negedge clk);
      chk("en_drop_after", bus.out[0], 0);
      count_window(PER - 11, -1, 8'h00, hi, ps_cnt, ps_last, first_val);
      chk("en_drop_ps_spacing", ps_last, 1);
      chk("en_drop_ps_count", ps_cnt, 1);

      // Random phase, with one async reset part way through.
      for (int it = 0; it < 40; it++) begin
         e = 16'($urandom);
         p = 16'($urandom);
         set_ep(e, p);
         case ($urandom_range(0, 5))
            0:       bus.pwm_duty_cycle = 8'hFF;
            1:       bus.pwm_duty_cycle = 8'h00;
            default: bus.pwm_duty_cycle = 8'($urandom);
         endcase
         repeat ($urandom_range(20, 150)) @(negedge clk);
         if (it == 20) begin
            #3 rst = 1'b1;
            #1;
            chk("rand_reset_out", bus.out, 16'h0000);
            @(negedge clk);
            rst = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
